// File: rtl/wb_skid_stage.sv
// -----------------------------------------------------------------------------
// wb_skid_stage
//
// Two-entry skid buffer sitting between the memory stage and the register-file
// write-back. The "main" entry drives the W_* outputs; the "skid" entry catches
// one extra instruction so that M_READY can be a pure register and never has a
// combinational path from W_READY.
//
// Ports
//   CLK        rising-edge clock
//   RST        synchronous, active-high reset
//   FLUSH      discard both buffered entries (pop in the same cycle still counts)
//   M_VALID    upstream entry present
//   M_READY    stage can accept an entry (registered: skid entry empty)
//   M_PC       upstream PC                       (XLEN)
//   M_INST     upstream instruction word         (XLEN)
//   M_REG_D    upstream destination register     (RA_W)
//   M_REG_D_V  upstream destination value        (XLEN)
//   W_VALID    head entry present
//   W_READY    downstream consumes head entry
//   W_PC, W_INST, W_REG_D, W_REG_D_V  head-entry fields, zero when W_VALID=0
//   W_WE       register-file write enable, suppressed for x0
//   OCC        number of buffered entries (0..2)
//   RETIRED    count of entries handed downstream, wraps modulo 2^CNT_W
// -----------------------------------------------------------------------------
module wb_skid_stage #(
    parameter int XLEN  = 32,
    parameter int RA_W  = 5,
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             FLUSH,
    input  logic             M_VALID,
    output logic             M_READY,
    input  logic [XLEN-1:0]  M_PC,
    input  logic [XLEN-1:0]  M_INST,
    input  logic [RA_W-1:0]  M_REG_D,
    input  logic [XLEN-1:0]  M_REG_D_V,
    output logic             W_VALID,
    input  logic             W_READY,
    output logic [XLEN-1:0]  W_PC,
    output logic [XLEN-1:0]  W_INST,
    output logic [RA_W-1:0]  W_REG_D,
    output logic [XLEN-1:0]  W_REG_D_V,
    output logic             W_WE,
    output logic [1:0]       OCC,
    output logic [CNT_W-1:0] RETIRED
);

    // Main entry (head, drives W_*)
    logic [XLEN-1:0]  main_pc_q,   main_pc_d;
    logic [XLEN-1:0]  main_inst_q, main_inst_d;
    logic [RA_W-1:0]  main_rd_q,   main_rd_d;
    logic [XLEN-1:0]  main_val_q,  main_val_d;

    // Skid entry (second in line)
    logic [XLEN-1:0]  skid_pc_q,   skid_pc_d;
    logic [XLEN-1:0]  skid_inst_q, skid_inst_d;
    logic [RA_W-1:0]  skid_rd_q,   skid_rd_d;
    logic [XLEN-1:0]  skid_val_q,  skid_val_d;

    // Control
    logic [1:0]       occ_q,     occ_d;
    logic             m_ready_q, m_ready_d;
    logic [CNT_W-1:0] retired_q, retired_d;

    logic w_valid;
    logic push;
    logic pop;

    assign w_valid = (occ_q != 2'd0);
    assign push    = M_VALID && m_ready_q;
    assign pop     = w_valid && W_READY;

    always_comb begin
        main_pc_d   = main_pc_q;
        main_inst_d = main_inst_q;
        main_rd_d   = main_rd_q;
        main_val_d  = main_val_q;
        skid_pc_d   = skid_pc_q;
        skid_inst_d = skid_inst_q;
        skid_rd_d   = skid_rd_q;
        skid_val_d  = skid_val_q;
        occ_d       = occ_q;

        // A pop is counted even when a flush wipes the buffers in the same
        // cycle: the consumer has already taken that instruction.
        retired_d = retired_q + {{(CNT_W-1){1'b0}}, pop};

        if (FLUSH) begin
            main_pc_d   = '0;
            main_inst_d = '0;
            main_rd_d   = '0;
            main_val_d  = '0;
            skid_pc_d   = '0;
            skid_inst_d = '0;
            skid_rd_d   = '0;
            skid_val_d  = '0;
            occ_d       = 2'd0;
        end else begin
            unique case (occ_q)
                2'd0: begin
                    if (push) begin
                        main_pc_d   = M_PC;
                        main_inst_d = M_INST;
                        main_rd_d   = M_REG_D;
                        main_val_d  = M_REG_D_V;
                        occ_d       = 2'd1;
                    end
                end
                2'd1: begin
                    if (push && pop) begin
                        // Head leaves, newcomer takes its place directly.
                        main_pc_d   = M_PC;
                        main_inst_d = M_INST;
                        main_rd_d   = M_REG_D;
                        main_val_d  = M_REG_D_V;
                    end else if (push) begin
                        skid_pc_d   = M_PC;
                        skid_inst_d = M_INST;
                        skid_rd_d   = M_REG_D;
                        skid_val_d  = M_REG_D_V;
                        occ_d       = 2'd2;
                    end else if (pop) begin
                        // Empty entries are kept zero so W_* read zero.
                        main_pc_d   = '0;
                        main_inst_d = '0;
                        main_rd_d   = '0;
                        main_val_d  = '0;
                        occ_d       = 2'd0;
                    end
                end
                2'd2: begin
                    // M_READY is low here, so push cannot happen.
                    if (pop) begin
                        main_pc_d   = skid_pc_q;
                        main_inst_d = skid_inst_q;
                        main_rd_d   = skid_rd_q;
                        main_val_d  = skid_val_q;
                        skid_pc_d   = '0;
                        skid_inst_d = '0;
                        skid_rd_d   = '0;
                        skid_val_d  = '0;
                        occ_d       = 2'd1;
                    end
                end
                default: begin
                    occ_d = 2'd0;
                end
            endcase
        end

        // Ready for the next cycle is decided here so the output is a flop.
        m_ready_d = (occ_d != 2'd2);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            main_pc_q   <= '0;
            main_inst_q <= '0;
            main_rd_q   <= '0;
            main_val_q  <= '0;
            skid_pc_q   <= '0;
            skid_inst_q <= '0;
            skid_rd_q   <= '0;
            skid_val_q  <= '0;
            occ_q       <= 2'd0;
            m_ready_q   <= 1'b1;
            retired_q   <= '0;
        end else begin
            main_pc_q   <= main_pc_d;
            main_inst_q <= main_inst_d;
            main_rd_q   <= main_rd_d;
            main_val_q  <= main_val_d;
            skid_pc_q   <= skid_pc_d;
            skid_inst_q <= skid_inst_d;
            skid_rd_q   <= skid_rd_d;
            skid_val_q  <= skid_val_d;
            occ_q       <= occ_d;
            m_ready_q   <= m_ready_d;
            retired_q   <= retired_d;
        end
    end

    // Head fields are gated by W_VALID as well as being zeroed on drain.
    assign M_READY   = m_ready_q;
    assign W_VALID   = w_valid;
    assign W_PC      = w_valid ? main_pc_q   : '0;
    assign W_INST    = w_valid ? main_inst_q : '0;
    assign W_REG_D   = w_valid ? main_rd_q   : '0;
    assign W_REG_D_V = w_valid ? main_val_q  : '0;
    assign W_WE      = w_valid && (main_rd_q != '0);
    assign OCC       = occ_q;
    assign RETIRED   = retired_q;

endmodule

// File: tb/tb_wb_skid_stage.sv
module tb_wb_skid_stage;
    localparam int XLEN  = 32;
    localparam int RA_W  = 5;
    localparam int CNT_W = 4;

    logic             CLK = 1'b0;
    logic             RST, FLUSH, M_VALID, M_READY, W_VALID, W_READY, W_WE;
    logic [XLEN-1:0]  M_PC, M_INST, M_REG_D_V, W_PC, W_INST, W_REG_D_V;
    logic [RA_W-1:0]  M_REG_D, W_REG_D;
    logic [1:0]       OCC;
    logic [CNT_W-1:0] RETIRED;

    always #5 CLK = ~CLK;

    wb_skid_stage #(.XLEN(XLEN), .RA_W(RA_W), .CNT_W(CNT_W)) dut (
        .CLK(CLK), .RST(RST), .FLUSH(FLUSH),
        .M_VALID(M_VALID), .M_READY(M_READY),
        .M_PC(M_PC), .M_INST(M_INST), .M_REG_D(M_REG_D), .M_REG_D_V(M_REG_D_V),
        .W_VALID(W_VALID), .W_READY(W_READY),
        .W_PC(W_PC), .W_INST(W_INST), .W_REG_D(W_REG_D), .W_REG_D_V(W_REG_D_V),
        .W_WE(W_WE), .OCC(OCC), .RETIRED(RETIRED)
    );

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
        logic [XLEN-1:0] val;
        logic [RA_W-1:0] rd;
    } ent_t;

    ent_t sb[$];        // expected in-flight entries, oldest first
    int   exp_ret = 0;  // expected RETIRED (mod 2^CNT_W)
    int   n_tests = 0;
    int   n_fail  = 0;
    int   bad_seen = 0; // times a discarded PC showed up on W_PC

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor / scoreboard: runs on the falling edge, where both the DUT
    // outputs and the inputs for the coming rising edge are stable.
    always @(negedge CLK) begin
        int   sz;
        bit   pop, push;
        ent_t h;
        sz = sb.size();
        chk("occ",     OCC,     sz);
        chk("m_ready", M_READY, (sz < 2));
        chk("w_valid", W_VALID, (sz > 0));
        chk("retired", RETIRED, exp_ret);
        if (W_VALID && (W_PC == 32'h208 || W_PC == 32'h300)) bad_seen++;
        if (sz > 0) begin
            h = sb[0];
            chk("w_pc",   W_PC,      h.pc);
            chk("w_inst", W_INST,    h.inst);
            chk("w_rd",   W_REG_D,   h.rd);
            chk("w_val",  W_REG_D_V, h.val);
            chk("w_we",   W_WE,      (h.rd != 0));
        end else begin
            chk("idle_fields", {W_PC, W_REG_D_V} | {W_INST, 27'd0, W_REG_D}, 64'd0);
            chk("idle_we", W_WE, 1'b0);
        end
        pop  = (sz > 0) && W_READY;
        push = M_VALID && (sz < 2);
        if (RST) begin
            sb.delete();
            exp_ret = 0;
        end else begin
            if (pop) begin
                void'(sb.pop_front());
                exp_ret = (exp_ret + 1) % (1 << CNT_W);
            end
            if (FLUSH) sb.delete();
            else if (push) sb.push_back('{pc: M_PC, inst: M_INST, val: M_REG_D_V, rd: M_REG_D});
        end
    end

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic v, input logic [XLEN-1:0] pc,
                         input logic [RA_W-1:0] rd, input logic [XLEN-1:0] val);
        M_VALID   = v;
        M_PC      = pc;
        M_INST    = pc ^ 32'hA5A5_0000;
        M_REG_D   = rd;
        M_REG_D_V = val;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        cyc();
        RST = 1'b0;
    endtask

    initial begin
        RST = 1'b1; FLUSH = 1'b0; W_READY = 1'b0;
        drive(1'b0, '0, '0, '0);
        cyc(); cyc();
        RST = 1'b0;
        chk("rst_m_ready", M_READY, 1'b1);
        chk("rst_occ", OCC, 2'd0);

        // Back-to-back stream with a free-flowing consumer
        W_READY = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h100 + 32'(4 * i), 5'd1, 32'(i));
            cyc();
        end
        drive(1'b0, '0, '0, '0);
        repeat (2) cyc();
        chk("stream_retired", RETIRED, 4'd3);

        // Backpressure: third push must be refused
        W_READY = 1'b0;
        drive(1'b1, 32'h200, 5'd2, 32'h22); cyc();
        drive(1'b1, 32'h204, 5'd3, 32'h33); cyc();
        chk("bp_occ", OCC, 2'd2);
        chk("bp_ready", M_READY, 1'b0);
        drive(1'b1, 32'h208, 5'd4, 32'h44); cyc(); cyc();
        chk("bp_hold_pc", W_PC, 32'h200);
        drive(1'b0, '0, '0, '0);
        W_READY = 1'b1;
        repeat (3) cyc();
        chk("bp_retired", RETIRED, 4'd5);

        // x0 write suppression
        W_READY = 1'b0;
        drive(1'b1, 32'h280, 5'd0, 32'hDEADBEEF); cyc();
        drive(1'b0, '0, '0, '0);
        chk("x0_valid", W_VALID, 1'b1);
        chk("x0_we", W_WE, 1'b0);
        W_READY = 1'b1;
        drive(1'b1, 32'h284, 5'd5, 32'hCAFEF00D); cyc();
        drive(1'b0, '0, '0, '0);
        chk("r5_we", W_WE, 1'b1);
        chk("r5_val", W_REG_D_V, 32'hCAFEF00D);
        cyc();

        // Flush while full, with a push in the same cycle
        W_READY = 1'b0;
        drive(1'b1, 32'h2F0, 5'd6, 32'h66); cyc();
        drive(1'b1, 32'h2F4, 5'd7, 32'h77); cyc();
        FLUSH = 1'b1;
        drive(1'b1, 32'h300, 5'd8, 32'h88); cyc();
        FLUSH = 1'b0;
        drive(1'b0, '0, '0, '0);
        chk("flush_occ", OCC, 2'd0);
        chk("flush_pc", W_PC, 32'd0);
        chk("flush_ready", M_READY, 1'b1);
        repeat (2) cyc();

        // Flush coinciding with a pop: the pop still retires
        drive(1'b1, 32'h310, 5'd9, 32'h99); cyc();
        drive(1'b0, '0, '0, '0);
        W_READY = 1'b1; FLUSH = 1'b1; cyc();
        FLUSH = 1'b0;
        chk("flush_pop_occ", OCC, 2'd0);

        // Counter wrap: 17 pops from a fresh reset
        do_reset();
        W_READY = 1'b1;
        for (int i = 0; i < 17; i++) begin
            drive(1'b1, 32'h400 + 32'(4 * i), 5'(i), 32'(i));
            cyc();
        end
        drive(1'b0, '0, '0, '0);
        cyc();
        chk("wrap_retired", RETIRED, 4'd1);

        // Reset while full
        W_READY = 1'b0;
        drive(1'b1, 32'h500, 5'd1, 32'h1); cyc();
        drive(1'b1, 32'h504, 5'd2, 32'h2); cyc();
        drive(1'b0, '0, '0, '0);
        chk("pre_rst_occ", OCC, 2'd2);
        W_READY = 1'b1;
        do_reset();
        chk("rst_mid_occ", OCC, 2'd0);
        chk("rst_mid_valid", W_VALID, 1'b0);
        chk("rst_mid_we", W_WE, 1'b0);
        chk("rst_mid_ready", M_READY, 1'b1);
        chk("rst_mid_ret", RETIRED, 4'd0);
        chk("rst_mid_pc", W_PC, 32'd0);

        // Randomized traffic against the queue model
        for (int i = 0; i < 600; i++) begin
            drive(1'($urandom_range(0, 1)), $urandom, 5'($urandom_range(0, 3)), $urandom);
            W_READY = 1'($urandom_range(0, 2) != 0);
            FLUSH   = ($urandom_range(0, 24) == 0);
            RST     = ($urandom_range(0, 79) == 0);
            cyc();
        end
        RST = 1'b0; FLUSH = 1'b0;
        drive(1'b0, '0, '0, '0);
        W_READY = 1'b1;
        repeat (4) cyc();

        chk("discarded_pc_seen", bad_seen, 0);
        @(negedge CLK);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
